sync_rptr_pipe: RTL

SYNC_RPTR_PIPE -- requirements
Module: sync_rptr_pipe

---
 rtl/sync_rptr_pipe.sv | 58 +++++
 1 files changed

// File: rtl/sync_rptr_pipe.sv
// sync_rptr_pipe: multi-flop Gray read-pointer synchronizer with binary conversion, advance delta and warm-up flag
module sync_rptr_pipe #(
  parameter int ADDRSIZE    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic [ADDRSIZE:0]   rptr,
  output logic [ADDRSIZE:0]   wq_rptr_gray,
  output logic [ADDRSIZE:0]   wq_rptr_bin,
  output logic [ADDRSIZE:0]   rptr_delta,
  output logic                rptr_adv,
  output logic                sync_valid
);
  localparam int W = ADDRSIZE + 1;
  localparam logic [2:0] WARM = 3'(SYNC_STAGES + 1);
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("SYNC_STAGES must be in 2..4");
  end
  logic [W-1:0] sync_q [SYNC_STAGES];
  logic [W-1:0] sync_d [SYNC_STAGES];
  logic [W-1:0] bin_q, bin_d, delta_q, delta_d;
  logic         adv_q, adv_d, valid_q, valid_d;
  logic [2:0]   cnt_q, cnt_d;
  // delta is only trusted once the chain holds post-reset samples
  always_comb begin
    sync_d[0] = rptr;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    bin_d = '0;
    for (int i = 0; i < W; i++) bin_d[i] = ^(sync_q[SYNC_STAGES-1] >> i);
    cnt_d   = (cnt_q == WARM) ? cnt_q : cnt_q + 3'd1;
    valid_d = valid_q | (cnt_q == WARM);
    delta_d = valid_q ? bin_d - bin_q : '0;
    adv_d   = delta_d != '0;
  end
  always_ff @(posedge wclk) begin
    if (wrst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      bin_q   <= '0;
      delta_q <= '0;
      adv_q   <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
      bin_q   <= bin_d;
      delta_q <= delta_d;
      adv_q   <= adv_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end
  assign wq_rptr_gray = sync_q[SYNC_STAGES-1];
  assign wq_rptr_bin  = bin_q;
  assign rptr_delta   = delta_q;
  assign rptr_adv     = adv_q;
  assign sync_valid   = valid_q;
endmodule
